// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor controller.
package serial_sub_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_sub (
   input  logic i_a,
   input  logic i_b,
   input  logic i_bin,
   output logic o_d,
   output logic o_bout
);

   assign o_d    = i_a ^ i_b ^ i_bin;
   assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: diff = a - b - bin, one bit per clock, LSB first.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_SIGNED_OVF_EN.
module serial_sub_ctrl
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int             CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_diff;
   logic [CW-1:0]    r_cnt;
   logic             r_borrow;
   logic             r_busy;
   logic             r_done;
   logic             r_bout;
   logic             w_d;
   logic             w_bo;
   logic [WIDTH-1:0] w_diff_nxt;

   full_sub u_full_sub (
      .i_a    (r_a[0]),
      .i_b    (r_b[0]),
      .i_bin  (r_borrow),
      .o_d    (w_d),
      .o_bout (w_bo)
   );

   // New difference bit enters at the MSB so the last bit lands everything in place.
   always_comb begin
      w_diff_nxt            = r_diff >> 1;
      w_diff_nxt[WIDTH-1]   = w_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_diff   <= '0;
         r_cnt    <= '0;
         r_borrow <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_bout   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_a      <= a;
                  r_b      <= b;
                  r_borrow <= bin;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= SHIFT;
               end
            end
            SHIFT: begin
               r_a      <= r_a >> 1;
               r_b      <= r_b >> 1;
               r_borrow <= w_bo;
               r_diff   <= w_diff_nxt;
               r_cnt    <= r_cnt + CW'(1);
               if (r_cnt == LAST) begin
                  r_bout  <= w_bo;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
   logic r_a_msb;
   logic r_b_msb;
   logic r_ovf;

   // Operand sign bits are kept aside because the operand registers shift out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_msb <= 1'b0;
         r_b_msb <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (r_state == IDLE && start) begin
         r_a_msb <= a[WIDTH-1];
         r_b_msb <= b[WIDTH-1];
      end else if (r_state == SHIFT && r_cnt == LAST) begin
         r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
      end else begin
         r_ovf <= r_ovf;
      end
   end

   assign ovf = r_ovf;
`else
   assign ovf = 1'b0;
`endif

   assign busy = r_busy;
   assign done = r_done;
   assign diff = r_diff;
   assign bout = r_bout;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed self-checking bench for serial_sub_ctrl (WIDTH=8 plus a WIDTH=1 instance).
module tb_serial_sub_ctrl;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       bin;
   logic       busy;
   logic       done;
   logic [7:0] diff;
   logic       bout;
   logic       ovf;

   logic       start1;
   logic [0:0] a1;
   logic [0:0] b1;
   logic       bin1;
   logic       busy1;
   logic       done1;
   logic [0:0] diff1;
   logic       bout1;
   logic       ovf1;

   int errors = 0;
   int checks = 0;

   serial_sub_ctrl #(.WIDTH(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
   );

   serial_sub_ctrl #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
      .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .ovf(ovf1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launch one operation and wait (bounded) for done; returns latency and busy-low count.
   task automatic run_op(input logic [7:0] ai, input logic [7:0] bi, input logic bini,
                         output int lat, output int busy_bad);
      @(negedge clk);
      a = ai; b = bi; bin = bini; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      busy_bad = 0;
      while (done !== 1'b1 && lat < 40) begin
         if (busy !== 1'b1) busy_bad++;
         @(negedge clk);
         lat++;
      end
      if (busy !== 1'b1) busy_bad++;
   endtask

   task automatic test_reset();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (diff !== 8'h00) begin errors++; $display("FAIL reset_diff: got %h want 00", diff); end
      checks++; if (bout !== 1'b0) begin errors++; $display("FAIL reset_bout: got %b want 0", bout); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
   endtask

   task automatic test_vector(input string name, input logic [7:0] ai, input logic [7:0] bi,
                              input logic bini, input logic [7:0] exp_d, input logic exp_b,
                              input logic exp_o);
      int lat;
      int bb;
      run_op(ai, bi, bini, lat, bb);
      checks++; if (lat !== 9) begin errors++; $display("FAIL %s_latency: got %0d want 9", name, lat); end
      checks++; if (bb !== 0) begin errors++; $display("FAIL %s_busy: low in %0d cycles want 0", name, bb); end
      checks++; if (diff !== exp_d) begin errors++; $display("FAIL %s_diff: got %h want %h", name, diff, exp_d); end
      checks++; if (bout !== exp_b) begin errors++; $display("FAIL %s_bout: got %b want %b", name, bout, exp_b); end
      checks++; if (ovf !== exp_o) begin errors++; $display("FAIL %s_ovf: got %b want %b", name, ovf, exp_o); end
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s_idle: got done=%b busy=%b want 0 0", name, done, busy); end
      checks++; if (diff !== exp_d) begin errors++; $display("FAIL %s_hold: got %h want %h", name, diff, exp_d); end
   endtask

   task automatic test_busy_ignore();
      int ndone = 0;
      logic [7:0] got = 8'h00;
      logic       gotb = 1'b1;
      @(negedge clk);
      a = 8'h35; b = 8'h12; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      for (int c = 1; c <= 20; c++) begin
         if (done === 1'b1) begin ndone++; got = diff; gotb = bout; end
         start = (c >= 3 && c <= 5);
         if (c == 3) begin a = 8'hFF; b = 8'hFF; bin = 1'b1; end
         @(negedge clk);
      end
      start = 1'b0;
      checks++; if (ndone !== 1) begin errors++; $display("FAIL busy_done_count: got %0d want 1", ndone); end
      checks++; if (got !== 8'h23) begin errors++; $display("FAIL busy_diff: got %h want 23", got); end
      checks++; if (gotb !== 1'b0) begin errors++; $display("FAIL busy_bout: got %b want 0", gotb); end
   endtask

   task automatic test_back_to_back();
      int lat;
      int bb;
      int n = 0;
      run_op(8'h00, 8'h01, 1'b0, lat, bb);
      a = 8'h10; b = 8'h0F; bin = 1'b1; start = 1'b1;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy: got %b want 0", busy); end
            checks++; if (diff !== 8'hFF) begin errors++; $display("FAIL b2b_hold: got %h want ff", diff); end
         end
         if (n == 2) start = 1'b0;
      end while (done !== 1'b1 && n < 40);
      start = 1'b0;
      checks++; if (n !== 10) begin errors++; $display("FAIL b2b_period: got %0d want 10", n); end
      checks++; if (diff !== 8'h00) begin errors++; $display("FAIL b2b_diff: got %h want 00", diff); end
      @(negedge clk);
   endtask

   task automatic test_reset_abort();
      int lat = 1;
      @(negedge clk);
      a = 8'h35; b = 8'h12; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_flags: got busy=%b done=%b want 0 0", busy, done); end
      checks++; if (diff !== 8'h00 || bout !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL abort_data: got diff=%h bout=%b ovf=%b want 00 0 0", diff, bout, ovf); end
      @(negedge clk);
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_no_done: got done=%b busy=%b want 0 0", done, busy); end
      rst_n = 1'b1;
      a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_first_accept: got busy=%b want 1", busy); end
      while (done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
      checks++; if (lat !== 9) begin errors++; $display("FAIL abort_restart_latency: got %0d want 9", lat); end
      checks++; if (diff !== 8'h7F) begin errors++; $display("FAIL abort_restart_diff: got %h want 7f", diff); end
      @(negedge clk);
   endtask

   task automatic test_width1();
      @(negedge clk);
      a1 = 1'b0; b1 = 1'b1; bin1 = 1'b0; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      checks++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin errors++; $display("FAIL w1_cycle1: got busy=%b done=%b want 1 0", busy1, done1); end
      @(negedge clk);
      checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL w1_done: got %b want 1", done1); end
      checks++; if (diff1 !== 1'b1 || bout1 !== 1'b1) begin errors++; $display("FAIL w1_result_a: got diff=%b bout=%b want 1 1", diff1, bout1); end
      @(negedge clk);
      a1 = 1'b1; b1 = 1'b0; bin1 = 1'b1; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      @(negedge clk);
      checks++; if (done1 !== 1'b1 || diff1 !== 1'b0 || bout1 !== 1'b0) begin errors++; $display("FAIL w1_result_b: got done=%b diff=%b bout=%b want 1 0 0", done1, diff1, bout1); end
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0;
      start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0;
      #23;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_vector("basic", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0);
      test_vector("wrap", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
      test_vector("borrow_in", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
      test_vector("overflow", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, OVF_ON);
      test_busy_ignore();
      test_back_to_back();
      test_reset_abort();
      test_width1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
